onehot_encode_pipe: RTL and testbench
=====================================

ONEHOT_ENCODE_PIPE -- requirements
Module: onehot_encode_pipe

Interface
REQ-001 Parameter ERR_CNT_W, default 8, SHALL set the error-counter width (legal range 1..16).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 in_valid  input  1  SHALL flag that in_onehot carries a word.
REQ-005 in_ready  output  1  SHALL flag that the block accepts a word this cycle.
REQ-006 in_onehot  input  8  SHALL carry the 8-bit one-hot word from the 3-to-8 decode stage.
REQ-007 out_valid  output  1  SHALL flag that out_sel/out_err hold a result.
REQ-008 out_ready  input  1  SHALL flag downstream acceptance.
REQ-009 out_sel  output  3  SHALL carry the encoded bit index.
REQ-010 out_err  output  1  SHALL flag that the word in out_sel was not exactly one-hot.
REQ-011 err_count  output  ERR_CNT_W  SHALL count accepted non-one-hot words.
REQ-012 err_sticky  output  1  SHALL flag that at least one error was accepted since last clear.
REQ-013 clr_err  input  1  SHALL clear err_count and err_sticky.

Function
REQ-014 Accept SHALL occur when in_valid && in_ready; emit SHALL occur when out_valid && out_ready.
REQ-015 in_ready SHALL equal !rst && (!out_valid || out_ready), combinational; full throughput, one word per cycle.
REQ-016 On accept, out_valid, out_sel, out_err SHALL load on the next rising edge (latency 1 cycle).
REQ-017 Emit without accept SHALL clear out_valid; simultaneous emit and accept SHALL replace the output with the new word and keep out_valid=1.
REQ-018 While out_valid && !out_ready, out_sel and out_err SHALL hold stable and in_ready SHALL be 0.
REQ-019 Exactly one bit set at position k: out_sel=k, out_err=0.
REQ-020 Zero bits set: out_sel=0, out_err=1.
REQ-021 Two or more bits set: out_sel=index of lowest set bit, out_err=1.
REQ-022 in_onehot SHALL be ignored when no accept occurs; no error is counted for unaccepted words.
REQ-023 Each accepted word with out_err condition SHALL increment err_count by 1 and set err_sticky, on the same edge the output register loads.
REQ-024 err_count SHALL saturate at 2^ERR_CNT_W-1; further errors leave it unchanged, err_sticky stays 1.
REQ-025 clr_err alone SHALL set err_count=0, err_sticky=0 next edge.
REQ-026 clr_err coincident with an accepted error SHALL yield err_count=1, err_sticky=1 (clear then count).
REQ-027 clr_err SHALL NOT affect out_valid, out_sel, out_err or the handshake.

Reset
REQ-028 With rst=1 at a rising edge: out_valid=0, out_sel=0, out_err=0, err_count=0, err_sticky=0.
REQ-029 While rst=1, in_ready SHALL be 0 and no word is accepted or counted.
REQ-030 Reset asserted while out_valid=1 and stalled SHALL drop the held word; no emit is signalled after reset.
REQ-031 First accept SHALL be possible in the first cycle with rst=0.

Verification
REQ-032 Stream 8'h01,8'h02,...,8'h80 with out_ready=1 each cycle -> out_sel 0..7 on consecutive cycles, one cycle after each input, out_err=0, err_count=0.
REQ-033 Accept 8'h04, hold out_ready=0 three cycles while in_valid=1 with 8'h10 -> out_sel=2 held, in_ready=0; release out_ready -> 8'h10 accepted, next cycle out_sel=4.
REQ-034 Accept 8'h00 then 8'h28 -> out_sel=0/out_err=1, then out_sel=3/out_err=1; err_count=2, err_sticky=1.
REQ-035 ERR_CNT_W=2, accept five 8'hFF words -> err_count 1,2,3,3,3; then clr_err with an accepted 8'h00 same cycle -> err_count=1, err_sticky=1.
REQ-036 Stall with out_valid=1 holding 8'h40, assert rst one cycle -> out_valid=0, all outputs 0, in_ready=0 during rst, 1 the cycle after.

Source files
------------

// File: rtl/onehot_encode_pipe.sv
// One-hot to binary encoder with a single valid/ready output register stage.
// Non-one-hot words are flagged, counted in a saturating error counter and
// latched in a sticky flag; both can be cleared with clr_err.
module onehot_encode_pipe #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_onehot,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_sel,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 err_sticky,
  input  logic                 clr_err
);

  logic                 accept;
  logic [2:0]           enc_sel;
  logic                 enc_found;
  logic                 enc_err;
  logic [ERR_CNT_W-1:0] cnt_base;
  logic [ERR_CNT_W-1:0] cnt_next;
  logic                 sticky_next;

  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Encode: index of lowest set bit; error unless exactly one bit is set.
  always_comb begin
    enc_sel   = '0;
    enc_found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (in_onehot[i] && !enc_found) begin
        enc_sel   = 3'(i);
        enc_found = 1'b1;
      end
    end
    enc_err = !((in_onehot != '0) && ((in_onehot & (in_onehot - 8'd1)) == '0));
  end

  // Output register: load on accept, drop valid on emit without accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sel   <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sel   <= enc_sel;
      out_err   <= enc_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Error bookkeeping: clear is applied first so a coincident error counts as 1.
  always_comb begin
    cnt_base    = clr_err ? '0 : err_count;
    cnt_next    = cnt_base;
    sticky_next = clr_err ? 1'b0 : err_sticky;
    if (accept && enc_err) begin
      sticky_next = 1'b1;
      if (cnt_base != '1) begin
        cnt_next = cnt_base + ERR_CNT_W'(1);
      end
    end
  end

  // Error counter and sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      err_count  <= cnt_next;
      err_sticky <= sticky_next;
    end
  end

endmodule

// File: tb/tb_onehot_encode_pipe.sv
// Directed, table-driven bench for onehot_encode_pipe. A second instance with
// a 2-bit error counter shares the stimulus to exercise counter saturation.
module tb_onehot_encode_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_onehot;
  logic       out_ready;
  logic       clr_err;

  logic       in_ready,  out_valid,  out_err,  err_sticky;
  logic [2:0] out_sel;
  logic [7:0] err_count;
  logic       in_ready2, out_valid2, out_err2, err_sticky2;
  logic [2:0] out_sel2;
  logic [1:0] err_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  onehot_encode_pipe #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_onehot(in_onehot), .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_err(out_err), .err_count(err_count),
    .err_sticky(err_sticky), .clr_err(clr_err)
  );

  onehot_encode_pipe #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_onehot(in_onehot), .out_valid(out_valid2), .out_ready(out_ready),
    .out_sel(out_sel2), .out_err(out_err2), .err_count(err_count2),
    .err_sticky(err_sticky2), .clr_err(clr_err)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] oh;
    logic       ordy;
    logic       clr;
    logic       e_ir;    // in_ready before the edge
    logic       e_ov;    // outputs after the edge
    logic [2:0] e_sel;
    logic       e_err;
    logic [7:0] e_cnt;
    logic       e_st;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check in_ready before the edge and the
  // registered outputs just after it. Data is only checked while valid.
  task automatic step(input vec_t v, input string tag);
    rst       = v.rst;
    in_valid  = v.iv;
    in_onehot = v.oh;
    out_ready = v.ordy;
    clr_err   = v.clr;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(v.e_ir));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.e_ov));
    if (v.e_ov) begin
      chk({tag, ".out_sel"}, 32'(out_sel), 32'(v.e_sel));
      chk({tag, ".out_err"}, 32'(out_err), 32'(v.e_err));
    end
    chk({tag, ".err_count"}, 32'(err_count), 32'(v.e_cnt));
    chk({tag, ".err_sticky"}, 32'(err_sticky), 32'(v.e_st));
  endtask

  function automatic vec_t mk(logic r, logic iv, logic [7:0] oh, logic ordy, logic clr,
                              logic ir, logic ov, logic [2:0] sel, logic err,
                              logic [7:0] cnt, logic st);
    vec_t v;
    v.rst = r; v.iv = iv; v.oh = oh; v.ordy = ordy; v.clr = clr;
    v.e_ir = ir; v.e_ov = ov; v.e_sel = sel; v.e_err = err; v.e_cnt = cnt; v.e_st = st;
    return v;
  endfunction

  initial begin
    //            rst iv  oh     ordy clr  ir  ov  sel   err cnt  st
    // one-hot stream, one result per cycle
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 1, 8'(1 << k), 1, 0, 1, 1, 3'(k), 0, 0, 0));
    // error patterns: zero, multi-bit (lowest index reported)
    tbl.push_back(mk(0, 1, 8'h00, 1, 0, 1, 1, 3'd0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 8'h28, 1, 0, 1, 1, 3'd3, 1, 2, 1));
    tbl.push_back(mk(0, 1, 8'h81, 1, 0, 1, 1, 3'd0, 1, 3, 1));
    tbl.push_back(mk(0, 1, 8'hC0, 1, 0, 1, 1, 3'd6, 1, 4, 1));
    tbl.push_back(mk(0, 1, 8'h80, 1, 0, 1, 1, 3'd7, 0, 4, 1));
    // emit without accept, unaccepted bad word not counted
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 3'd0, 0, 4, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 3'd0, 0, 4, 1));
    // clr alone, then clr with accepted error
    tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 0, 3'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h03, 1, 1, 1, 1, 3'd0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 8'h10, 1, 0, 1, 1, 3'd4, 0, 1, 1));
    // clr during stall leaves output intact; stalled word not accepted
    tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 1, 3'd4, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 1, 3'd4, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 3'd0, 0, 0, 0));

    rst = 1; in_valid = 1; in_onehot = 8'hFF; out_ready = 1; clr_err = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'(0));
    chk("reset.out_valid", 32'(out_valid), 32'(0));
    chk("reset.out_sel", 32'(out_sel), 32'(0));
    chk("reset.out_err", 32'(out_err), 32'(0));
    chk("reset.err_count", 32'(err_count), 32'(0));
    chk("reset.err_sticky", 32'(err_sticky), 32'(0));

    // first accept on the very first cycle out of reset
    step(mk(0, 1, 8'h20, 1, 0, 1, 1, 3'd5, 0, 0, 0), "first");

    foreach (tbl[i]) step(tbl[i], $sformatf("tbl%0d", i));

    // backpressure: hold 8'h04 for three stalled cycles, then take 8'h10
    step(mk(0, 1, 8'h04, 1, 0, 1, 1, 3'd2, 0, 0, 0), "bp.load");
    for (int i = 0; i < 3; i++)
      step(mk(0, 1, 8'h10, 0, 0, 0, 1, 3'd2, 0, 0, 0), $sformatf("bp.stall%0d", i));
    step(mk(0, 1, 8'h10, 1, 0, 1, 1, 3'd4, 0, 0, 0), "bp.release");
    step(mk(0, 0, 8'h00, 1, 0, 1, 0, 3'd0, 0, 0, 0), "bp.drain");

    // counter saturation: narrow counter 1,2,3,3,3; wide counter keeps going
    step(mk(0, 0, 8'h00, 1, 1, 1, 0, 3'd0, 0, 0, 0), "sat.clr");
    chk("sat.clr.cnt2", 32'(err_count2), 32'(0));
    for (int i = 0; i < 5; i++) begin
      step(mk(0, 1, 8'hFF, 1, 0, 1, 1, 3'd0, 1, 8'(i + 1), 1), $sformatf("sat%0d", i));
      chk($sformatf("sat%0d.cnt2", i), 32'(err_count2), (i < 3) ? 32'(i + 1) : 32'(3));
      chk($sformatf("sat%0d.sticky2", i), 32'(err_sticky2), 32'(1));
    end
    step(mk(0, 1, 8'h00, 1, 1, 1, 1, 3'd0, 1, 1, 1), "sat.clrerr");
    chk("sat.clrerr.cnt2", 32'(err_count2), 32'(1));
    chk("sat.clrerr.sticky2", 32'(err_sticky2), 32'(1));
    // wide counter saturates at 255 after 255 more errors (total 256)
    rst = 0; in_valid = 1; in_onehot = 8'h06; out_ready = 1; clr_err = 0;
    repeat (255) @(posedge clk);
    #1;
    chk("sat8.at_max", 32'(err_count), 32'(255));
    step(mk(0, 1, 8'h06, 1, 0, 1, 1, 3'd1, 1, 255, 1), "sat8.hold");

    // reset while stalled with a held word drops it
    step(mk(0, 0, 8'h00, 1, 1, 1, 0, 3'd0, 0, 0, 0), "rs.clr");
    step(mk(0, 1, 8'h40, 1, 0, 1, 1, 3'd6, 0, 0, 0), "rs.load");
    step(mk(0, 0, 8'h00, 0, 0, 0, 1, 3'd6, 0, 0, 0), "rs.stall");
    step(mk(1, 1, 8'h00, 0, 0, 0, 0, 3'd0, 0, 0, 0), "rs.rst");
    chk("rs.rst.out_sel", 32'(out_sel), 32'(0));
    chk("rs.rst.out_err", 32'(out_err), 32'(0));
    step(mk(0, 0, 8'h00, 0, 0, 1, 0, 3'd0, 0, 0, 0), "rs.after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
